// File: rtl/soc_timer.sv
// Programmable 16-bit interval timer for the j68 SoC bus: prescaler, one-shot or
// auto-reload, a sticky ZERO flag with overrun, and an active-low level-3 interrupt.
module soc_timer #(
  parameter int unsigned PRESC_W = 8,
  parameter logic [15:0] CNT_RST = 16'hFFFF
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        clk_ena,
  input  logic        cs,
  input  logic        rd_ena,
  input  logic        wr_ena,
  input  logic [1:0]  byte_ena,
  input  logic [1:0]  addr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        data_ack,
  output logic        irq_n
);

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_RELOAD = 2'd2;
  localparam logic [1:0] A_COUNT  = 2'd3;

  logic               r_en;
  logic               r_auto;
  logic               r_ie;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_pcnt;
  logic               r_zero;
  logic               r_ovr;
  logic [15:0]        r_reload;
  logic [15:0]        r_count;
  logic [15:0]        r_rd_data;
  logic               r_rd_dly;
  logic               r_irq_n;

  logic               w_wr;
  logic               w_rd;
  logic               w_wr_ctrl;
  logic               w_wr_status;
  logic               w_wr_reload;
  logic               w_wr_count;
  logic               w_start;
  logic               w_tick;
  logic               w_expire;
  logic               w_clr_zero;
  logic               w_clr_ovr;
  logic [PRESC_W-1:0] w_presc_nxt;
  logic [15:0]        w_rd_mux;

  function automatic logic [15:0] f_merge(input logic [15:0] old_v,
                                          input logic [15:0] new_v,
                                          input logic [1:0]  be);
    return {be[1] ? new_v[15:8] : old_v[15:8], be[0] ? new_v[7:0] : old_v[7:0]};
  endfunction

  // Bus decode and timer event qualification
  always_comb begin
    w_wr        = cs & wr_ena & clk_ena;
    w_rd        = cs & rd_ena & clk_ena;
    w_wr_ctrl   = w_wr & (addr == A_CTRL);
    w_wr_status = w_wr & (addr == A_STATUS);
    w_wr_reload = w_wr & (addr == A_RELOAD);
    w_wr_count  = w_wr & (addr == A_COUNT);
    w_presc_nxt = byte_ena[1] ? wr_data[8 +: PRESC_W] : r_presc;
    w_start     = w_wr_ctrl & byte_ena[0] & wr_data[0] & ~r_en;
    w_tick      = r_en & (r_pcnt == '0);
    // A same-edge COUNT write discards the tick's decrement or expiry
    w_expire    = w_tick & (r_count == 16'd0) & ~w_wr_count;
    w_clr_zero  = w_wr_status & byte_ena[0] & wr_data[0];
    w_clr_ovr   = w_wr_status & byte_ena[0] & wr_data[1];
  end

  always_comb begin
    w_rd_mux = '0;
    case (addr)
      A_CTRL: begin
        w_rd_mux[2:0]           = {r_ie, r_auto, r_en};
        w_rd_mux[8 +: PRESC_W]  = r_presc;
      end
      A_STATUS: w_rd_mux[2:0]   = {r_en, r_ovr, r_zero};
      A_RELOAD: w_rd_mux        = r_reload;
      default:  w_rd_mux        = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en      <= 1'b0;
      r_auto    <= 1'b0;
      r_ie      <= 1'b0;
      r_presc   <= '0;
      r_pcnt    <= '0;
      r_zero    <= 1'b0;
      r_ovr     <= 1'b0;
      r_reload  <= CNT_RST;
      r_count   <= CNT_RST;
      r_rd_data <= '0;
      r_rd_dly  <= 1'b0;
      r_irq_n   <= 1'b1;
    end else if (clk_ena) begin
      r_rd_dly <= cs & rd_ena;
      if (w_rd) r_rd_data <= w_rd_mux;
      r_irq_n <= ~(r_zero & r_ie);

      if (w_wr_ctrl & byte_ena[0]) begin
        r_en   <= wr_data[0];
        r_auto <= wr_data[1];
        r_ie   <= wr_data[2];
      end else if (w_expire & ~r_auto) begin
        r_en <= 1'b0;
      end
      if (w_wr_ctrl & byte_ena[1]) r_presc <= w_presc_nxt;

      if (w_start) r_pcnt <= w_presc_nxt;
      else if (r_en) r_pcnt <= w_tick ? r_presc : r_pcnt - PRESC_W'(1);

      if (w_wr_count) r_count <= f_merge(r_count, wr_data, byte_ena);
      else if (w_tick) begin
        if (r_count != 16'd0) r_count <= r_count - 16'd1;
        else if (r_auto)      r_count <= r_reload;
        else                  r_count <= 16'd0;
      end

      if (w_wr_reload) r_reload <= f_merge(r_reload, wr_data, byte_ena);

      // Expiry wins over a same-edge software clear
      r_zero <= (r_zero & ~w_clr_zero) | w_expire;
      r_ovr  <= (r_ovr & ~w_clr_ovr) | (w_expire & r_zero);
    end
  end

  assign rd_data  = r_rd_data;
  assign data_ack = w_wr | r_rd_dly;
  assign irq_n    = r_irq_n;

endmodule
